// File: rtl/mem_arbiter.sv
// Arbitrates the external memory bus between instruction fetch and data load/store.
// Data wins ties unless fetch has lost STARVE_LIMIT times in a row; a watchdog aborts hung accesses.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
    output logic        m_instr_access,
    output logic        m_read_done,
    input  logic [15:0] m_rdata,
    input  logic        m_busy,
    input  logic        m_ready,
    output logic [1:0]  owner
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE  = 2'b00;
    localparam logic [1:0] OWN_FETCH = 2'b01;
    localparam logic [1:0] OWN_DATA  = 2'b10;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  owner_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        we_q;
    logic        err_q;
    logic [3:0]  starve_cnt;
    logic [7:0]  wd_cnt;

    logic grant_fetch;
    logic is_write;
    logic strobe;

    assign grant_fetch = f_req && (!d_req || starve_cnt == STARVE_MAX);
    assign is_write    = (owner_q == OWN_DATA) && we_q;
    assign strobe      = (state == ST_ISSUE) && !m_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            starve_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        state <= ST_ISSUE;
                        if (grant_fetch) begin
                            owner_q    <= OWN_FETCH;
                            addr_q     <= f_addr;
                            we_q       <= 1'b0;
                            starve_cnt <= '0;
                        end else begin
                            owner_q <= OWN_DATA;
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                            // Only a data grant that actually bypasses a waiting fetch counts toward starvation
                            if (!f_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!m_busy) begin
                        state  <= ST_WAIT;
                        wd_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    // m_ready takes precedence over a watchdog expiry in the same cycle
                    if (m_ready) begin
                        rdata_q <= m_rdata;
                        err_q   <= 1'b0;
                        state   <= ST_DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        rdata_q <= 16'hFFFF;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    owner_q <= OWN_NONE;
                    wd_cnt  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_addr         = addr_q;
    assign m_wdata        = wdata_q;
    assign m_read         = strobe && !is_write;
    assign m_write        = strobe && is_write;
    assign m_instr_access = (owner_q == OWN_FETCH) && (state != ST_IDLE);
    assign m_read_done    = (state == ST_DONE) && !is_write;
    assign owner          = owner_q;

    assign f_ack   = (state == ST_DONE) && (owner_q == OWN_FETCH);
    assign d_ack   = (state == ST_DONE) && (owner_q == OWN_DATA);
    assign f_rdata = rdata_q;
    assign d_rdata = rdata_q;
    assign f_err   = f_ack && err_q;
    assign d_err   = d_ack && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, starvation and reset sequences,
// randomized transactions against a transaction-level model, and a short-watchdog instance.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, f_req, d_req, d_we, m_busy, m_ready, use2, rst2;
    logic [15:0] f_addr, d_addr, d_wdata, m_rdata;

    logic        f_ack1, f_err1, d_ack1, d_err1, m_read1, m_write1, m_ia1, m_rd1;
    logic [15:0] f_rdata1, d_rdata1, m_addr1, m_wdata1;
    logic [1:0]  owner1;
    logic        f_ack2, f_err2, d_ack2, d_err2, m_read2, m_write2, m_ia2, m_rd2;
    logic [15:0] f_rdata2, d_rdata2, m_addr2, m_wdata2;
    logic [1:0]  owner2;

    logic        o_f_ack, o_f_err, o_d_ack, o_d_err, o_m_read, o_m_write, o_m_ia, o_m_rd;
    logic [15:0] o_f_rdata, o_d_rdata, o_m_addr, o_m_wdata;
    logic [1:0]  o_owner;
    logic [73:0] all_out;

    // Second instance has a 3-cycle watchdog and is held in reset unless selected
    assign rst2 = rst & use2;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack1), .f_rdata(f_rdata1), .f_err(f_err1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
        .m_addr(m_addr1), .m_wdata(m_wdata1), .m_read(m_read1), .m_write(m_write1),
        .m_instr_access(m_ia1), .m_read_done(m_rd1),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_ready(m_ready), .owner(owner1)
    );

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(3)) dut_to3 (
        .clk(clk), .rst(rst2),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack2), .f_rdata(f_rdata2), .f_err(f_err2),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack2), .d_rdata(d_rdata2), .d_err(d_err2),
        .m_addr(m_addr2), .m_wdata(m_wdata2), .m_read(m_read2), .m_write(m_write2),
        .m_instr_access(m_ia2), .m_read_done(m_rd2),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_ready(m_ready), .owner(owner2)
    );

    assign o_f_ack   = use2 ? f_ack2   : f_ack1;
    assign o_f_err   = use2 ? f_err2   : f_err1;
    assign o_f_rdata = use2 ? f_rdata2 : f_rdata1;
    assign o_d_ack   = use2 ? d_ack2   : d_ack1;
    assign o_d_err   = use2 ? d_err2   : d_err1;
    assign o_d_rdata = use2 ? d_rdata2 : d_rdata1;
    assign o_m_addr  = use2 ? m_addr2  : m_addr1;
    assign o_m_wdata = use2 ? m_wdata2 : m_wdata1;
    assign o_m_read  = use2 ? m_read2  : m_read1;
    assign o_m_write = use2 ? m_write2 : m_write1;
    assign o_m_ia    = use2 ? m_ia2    : m_ia1;
    assign o_m_rd    = use2 ? m_rd2    : m_rd1;
    assign o_owner   = use2 ? owner2   : owner1;
    assign all_out   = {o_f_ack, o_f_rdata, o_f_err, o_d_ack, o_d_rdata, o_d_err, o_m_addr,
                        o_m_wdata, o_m_read, o_m_write, o_m_ia, o_m_rd, o_owner};

    typedef struct {
        logic        fr, dr, we;
        logic [15:0] fa, da, dw, md;
        int          busy;      // ISSUE cycles with m_busy=1
        int          k;         // WAIT cycle carrying m_ready; 0 = never (timeout)
        logic        exp_f;     // 1 = fetch expected to win
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   starve = 0;
    vec_t tbl[9];
    vec_t v, p;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        starve = 0;
    endtask

    // Transaction-level reference: grant choice, starvation count and returned data
    task automatic predict(input vec_t vi, output vec_t vo);
        vo = vi;
        if (vi.fr && (!vi.dr || starve == LIMIT)) begin
            vo.exp_f = 1'b1;
            starve = 0;
        end else begin
            vo.exp_f = 1'b0;
            starve = vi.fr ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        end
        vo.exp_rd  = (vi.k == 0) ? 16'hFFFF : vi.md;
        vo.exp_err = (vi.k == 0);
    endtask

    // Entered at posedge+1 of a cycle where the DUT is IDLE; returns at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input vec_t t, input bit keep, input int to);
        logic        is_wr;
        logic [1:0]  exp_own;
        logic [15:0] exp_addr;
        int          w;
        is_wr    = !t.exp_f && t.we;
        exp_own  = t.exp_f ? 2'b01 : 2'b10;
        exp_addr = t.exp_f ? t.fa : t.da;
        f_req = t.fr; d_req = t.dr; f_addr = t.fa; d_addr = t.da; d_we = t.we; d_wdata = t.dw;
        m_busy = (t.busy > 0); m_ready = 1'b0;
        @(negedge clk);
        chk("idle_quiet", {o_owner, o_f_ack, o_d_ack, o_m_read, o_m_write, o_m_ia, o_m_rd}, 0);
        tick();
        f_addr = ~t.fa; d_addr = ~t.da; d_wdata = ~t.dw; d_we = ~t.we;
        for (int b = 0; b < t.busy; b++) begin
            m_ready = 1'b1; m_rdata = 16'hDEAD;
            @(negedge clk);
            chk("busy_no_strobe", {o_m_read, o_m_write}, 2'b00);
            chk("issue_owner", o_owner, exp_own);
            tick();
        end
        m_busy = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("strobe", {o_m_read, o_m_write}, is_wr ? 2'b01 : 2'b10);
        chk("m_addr", o_m_addr, exp_addr);
        if (is_wr) chk("m_wdata", o_m_wdata, t.dw);
        chk("instr_access", o_m_ia, t.exp_f);
        chk("issue_owner", o_owner, exp_own);
        tick();
        w = 1;
        forever begin
            if (w == t.k) begin m_ready = 1'b1; m_rdata = t.md; end
            @(negedge clk);
            chk("wait_quiet", {o_f_ack, o_d_ack, o_m_read, o_m_write, o_m_rd}, 0);
            chk("wait_addr", o_m_addr, exp_addr);
            if (w == t.k || w == to) break;
            tick();
            w++;
        end
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("f_ack", o_f_ack, t.exp_f);
        chk("d_ack", o_d_ack, !t.exp_f);
        if (!is_wr || t.k == 0)
            chk("rdata", t.exp_f ? o_f_rdata : o_d_rdata, t.exp_rd);
        chk("err", t.exp_f ? o_f_err : o_d_err, t.exp_err);
        chk("read_done", o_m_rd, !is_wr);
        chk("done_owner", o_owner, exp_own);
        chk("done_access", o_m_ia, t.exp_f);
        chk("done_addr", o_m_addr, exp_addr);
        tick();
        if (!keep) begin f_req = 1'b0; d_req = 1'b0; end
    endtask

    initial begin
        //           fr dr we fa        da        dw        md        busy k  exp_f exp_rd    exp_err
        tbl[0] = '{1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF, 0, 3, 1, 16'hBEEF, 0};
        tbl[1] = '{0, 1, 1, 16'h0000, 16'h2000, 16'h1234, 16'h0000, 5, 2, 0, 16'h0000, 0};
        tbl[2] = '{0, 1, 0, 16'h0000, 16'h3000, 16'h0000, 16'hCAFE, 0, 1, 0, 16'hCAFE, 0};
        tbl[3] = '{1, 1, 0, 16'h0200, 16'h4000, 16'h0000, 16'h1111, 0, 2, 0, 16'h1111, 0};
        tbl[4] = '{1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0F0F, 2, 4, 1, 16'h0F0F, 0};
        tbl[5] = '{0, 1, 0, 16'h0000, 16'h0001, 16'h0000, 16'hA5A5, 1, 1, 0, 16'hA5A5, 0};
        tbl[6] = '{1, 0, 0, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'hFFFF, 1};
        tbl[7] = '{0, 1, 0, 16'h0000, 16'h7000, 16'h0000, 16'h7777, 0, 2, 0, 16'h7777, 0};
        tbl[8] = '{0, 1, 1, 16'h0000, 16'h8000, 16'hAAAA, 16'h0000, 1, 0, 0, 16'hFFFF, 1};

        use2 = 1'b0; rst = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", all_out, 0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0, 255);

        // Both requesters held continuously: D,D,D,D,F repeating
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = '{1, 1, 0, 16'h1000 + 16'(i), 16'h9000 + 16'(i), 16'h0, 16'(i * 7 + 3), 0, 1,
                  (i == 4 || i == 9), 16'(i * 7 + 3), 0};
            run_txn(v, 1'b1, 255);
        end
        f_req = 1'b0; d_req = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            v.fr = 1'($urandom % 2); v.dr = 1'($urandom % 2);
            if (!v.fr && !v.dr) v.dr = 1'b1;
            v.we = 1'($urandom % 2);
            v.fa = 16'($urandom); v.da = 16'($urandom); v.dw = 16'($urandom); v.md = 16'($urandom);
            v.busy = $urandom_range(0, 3); v.k = $urandom_range(1, 6);
            predict(v, p);
            run_txn(p, 1'($urandom % 2), 255);
        end
        f_req = 1'b0; d_req = 1'b0;

        // Reset in WAIT abandons the transaction; a late m_ready is ignored
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h5555; m_busy = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_seq_strobe", {o_m_read, o_m_write}, 2'b10);
        tick();
        d_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_seq_wait", {o_d_ack, o_owner}, 3'b010);
        tick();
        m_ready = 1'b1; m_rdata = 16'h9999;
        @(negedge clk);
        chk("rst_seq_zero", all_out, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_seq_no_ack", all_out, 0);
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("rst_seq_idle", all_out, 0);
        tick();
        starve = 0;
        v = '{1, 0, 0, 16'h0ABC, 16'h0, 16'h0, 16'h4321, 0, 2, 1, 16'h4321, 0};
        run_txn(v, 1'b0, 255);

        // Short-watchdog instance: tie goes to m_ready, then a real timeout, then recovery
        do_reset();
        use2 = 1'b1;
        v = '{1, 0, 0, 16'h0400, 16'h0, 16'h0, 16'h5A5A, 0, 3, 1, 16'h5A5A, 0};
        run_txn(v, 1'b0, 3);
        v = '{0, 1, 0, 16'h0, 16'h0500, 16'h0, 16'h0000, 0, 0, 0, 16'hFFFF, 1};
        run_txn(v, 1'b0, 3);
        v = '{0, 1, 0, 16'h0, 16'h0600, 16'h0, 16'h1357, 0, 2, 0, 16'h1357, 0};
        run_txn(v, 1'b0, 3);
        use2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
